// File: rtl/tail_light_pkg.sv
// tail_light_pkg: lamp-controller state encoding and request-priority decode.
package tail_light_pkg;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_e;

    // Hazard wins, and left+right together is treated as hazard.
    function automatic state_e decode_req(input logic left, input logic right, input logic hazard);
        return (hazard || (left && right)) ? HAZ : left ? LEFT : right ? RIGHT : IDLE;
    endfunction

endpackage

// File: rtl/tail_light_seq_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every DIV clocks (constant 1 when DIV=1).
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tail_light_seq.sv
// tail_light_seq: tick-paced turn/hazard tail-light sequencer.
// Optional TAIL_LIGHT_BRAKE_EN adds a brake pin lighting every non-animating bank.
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS = 3,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
`ifdef TAIL_LIGHT_BRAKE_EN
    input  logic             brake,
`endif
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic             busy
);

    localparam int SW = $clog2(LAMPS + 1);

    state_e           state_q, state_d, mode;
    logic [SW-1:0]    step_q, step_d;
    logic [LAMPS-1:0] fill;
    logic             tick, hz, brk;

    tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

`ifdef TAIL_LIGHT_BRAKE_EN
    assign brk = brake;
`else
    assign brk = 1'b0;
`endif

    always_comb begin
        mode    = decode_req(left, right, hazard);
        state_d = state_q;
        step_d  = step_q;
        if (tick) begin
            if (mode != state_q) begin
                state_d = mode;
                step_d  = (mode == IDLE) ? '0 : SW'(1);
            end else if (state_q == HAZ) begin
                step_d = (step_q == SW'(1)) ? '0 : SW'(1);
            end else if (state_q != IDLE) begin
                step_d = (step_q == SW'(LAMPS)) ? '0 : step_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Thermometer fill: lowest step_q lamps lit.
    always_comb begin
        for (int i = 0; i < LAMPS; i++) fill[i] = (i < int'(step_q));
    end

    assign hz = (state_q == HAZ) && (step_q == SW'(1));

    always_comb begin
        lamp_l = (state_q == LEFT)  ? fill : {LAMPS{(state_q == HAZ) ? hz : brk}};
        lamp_r = (state_q == RIGHT) ? fill : {LAMPS{(state_q == HAZ) ? hz : brk}};
        busy   = (state_q != IDLE);
    end

endmodule
